// File: rtl/modulo_top_pkg.sv
// Shared definitions for the SECDED receiver/display block: error classes,
// active-low 7-segment glyphs ({g,f,e,d,c,b,a}, bit0 = a) and a hex decoder.
package modulo_top_pkg;

    typedef enum logic [1:0] {
        NO_ERR     = 2'd0,
        SINGLE_ERR = 2'd1,
        DOUBLE_ERR = 2'd2
    } err_class_e;

    // Hamming position reported when only the overall parity bit is hit
    localparam logic [3:0] POS_OVERALL_PARITY = 4'd8;

    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ERR   = SEG_HEX_E;

    // Nibble to active-low segment pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (value)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            4'hF: seg = SEG_HEX_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/modulo_top_if.sv
// Bundle of the data/display signals of modulo_top. The source of the
// codeword and reference nibble drives through the master modport; the
// display side observes through the slave modport.
interface modulo_top_if;
    import modulo_top_pkg::*;

    logic [3:0] entrada;
    logic [7:0] palabra_rx;
    logic       select_pos;
    logic [6:0] display_left;
    logic [6:0] display_right;
    logic [3:0] led_out;

    modport master (
        output entrada,
        output palabra_rx,
        output select_pos,
        input  display_left,
        input  display_right,
        input  led_out
    );

    modport slave (
        input  entrada,
        input  palabra_rx,
        input  select_pos,
        output display_left,
        output display_right,
        output led_out
    );
endinterface

// File: rtl/secded_decoder.sv
// Combinational extended-Hamming(8,4) decoder. Codeword bit i-1 is Hamming
// position i (p1,p2,d1,p4,d2,d3,d4), bit 7 is even parity over bits 6:0.
module secded_decoder
    import modulo_top_pkg::*;
(
    input  logic [7:0]  i_palabra,
    output logic [2:0]  o_syndrome,
    output err_class_e  o_err_class,
    output logic [3:0]  o_data_corr,
    output logic [3:0]  o_data_raw
);

    logic [6:0]       w_hamming;
    logic [2:0][6:0]  w_terms;
    logic [2:0]       w_syndrome;
    logic             w_pe;
    logic [6:0]       w_flip;
    logic [6:0]       w_fixed;

    assign w_hamming = i_palabra[6:0];

    // Syndrome bit gi covers every position whose index has bit gi set
    for (genvar gi = 0; gi < 3; gi++) begin : g_syn
        for (genvar gj = 0; gj < 7; gj++) begin : g_term
            if ((((gj + 1) >> gi) % 2) == 1) begin : g_in
                assign w_terms[gi][gj] = w_hamming[gj];
            end else begin : g_out
                assign w_terms[gi][gj] = 1'b0;
            end
        end
        assign w_syndrome[gi] = ^w_terms[gi];
    end

    assign w_pe = ^i_palabra;

    // Invert the single position named by the syndrome; syndrome 0 with bad
    // overall parity means only bit 7 was hit, so no data bit moves.
    for (genvar gi = 0; gi < 7; gi++) begin : g_flip
        assign w_flip[gi] = w_pe && (w_syndrome == 3'(gi + 1));
    end

    assign w_fixed = w_hamming ^ w_flip;

    // Classify from syndrome and overall parity
    always_comb begin
        o_err_class = NO_ERR;
        if (w_pe) begin
            o_err_class = SINGLE_ERR;
        end else if (w_syndrome != 3'd0) begin
            o_err_class = DOUBLE_ERR;
        end
    end

    assign o_syndrome  = w_syndrome;
    assign o_data_corr = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
    assign o_data_raw  = {w_hamming[6], w_hamming[5], w_hamming[4], w_hamming[2]};

endmodule

// File: rtl/modulo_top.sv
// SECDED receiver with two 7-segment digits and a LED nibble. Every cycle is
// evaluated independently; all outputs are registered one edge after the
// inputs are sampled and blank asynchronously while reset is held.
module modulo_top
    import modulo_top_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] entrada,
    input  logic [7:0] palabra_rx,
    input  logic       select_pos,
    output logic [6:0] display_left,
    output logic [6:0] display_right,
    output logic [3:0] led_out
);

    logic [2:0]  w_syndrome;
    err_class_e  w_err_class;
    logic [3:0]  w_data_corr;
    logic [3:0]  w_data_raw;

    logic [3:0]  w_led_next;
    logic [3:0]  w_err_pos;
    logic [6:0]  w_left_next;
    logic [6:0]  w_right_next;

    logic [3:0]  r_led;
    logic [6:0]  r_left;
    logic [6:0]  r_right;

    secded_decoder u_decoder (
        .i_palabra   (palabra_rx),
        .o_syndrome  (w_syndrome),
        .o_err_class (w_err_class),
        .o_data_corr (w_data_corr),
        .o_data_raw  (w_data_raw)
    );

    // Pick LED data and the error-position digit from the decoder result
    always_comb begin
        w_led_next = w_data_corr;
        w_err_pos  = 4'd0;
        case (w_err_class)
            SINGLE_ERR: w_err_pos = (w_syndrome == 3'd0) ? POS_OVERALL_PARITY
                                                         : {1'b0, w_syndrome};
            DOUBLE_ERR: w_led_next = w_data_raw;
            default:    w_err_pos = 4'd0;
        endcase
    end

    // Display muxing: 'E' on uncorrectable words overrides the selector
    always_comb begin
        w_left_next  = hex_to_seg(entrada);
        w_right_next = hex_to_seg(w_led_next);
        if (w_err_class == DOUBLE_ERR) begin
            w_right_next = SEG_ERR;
        end else if (select_pos) begin
            w_right_next = hex_to_seg(w_err_pos);
        end
    end

    // Output registers, blanked asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led   <= 4'b0000;
            r_left  <= SEG_BLANK;
            r_right <= SEG_BLANK;
        end else begin
            r_led   <= w_led_next;
            r_left  <= w_left_next;
            r_right <= w_right_next;
        end
    end

    assign led_out       = r_led;
    assign display_left  = r_left;
    assign display_right = r_right;

endmodule

// File: tb/tb_modulo_top.sv
// Directed bench for modulo_top: reset behaviour, the worked codewords, a
// sweep of every nibble with every single-bit flip, and cycle-by-cycle use.
module tb_modulo_top;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    modulo_top_if bus ();

    modulo_top dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .entrada       (bus.entrada),
        .palabra_rx    (bus.palabra_rx),
        .select_pos    (bus.select_pos),
        .display_left  (bus.display_left),
        .display_right (bus.display_right),
        .led_out       (bus.led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written glyph table (active-low gfedcba)
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Reference encoder: positions 1..7 = p1,p2,d1,p4,d2,d3,d4, bit 7 parity
    function automatic logic [7:0] encode(input logic [3:0] d);
        logic p1, p2, p4;
        logic [6:0] w7;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        w7 = {d[3], d[2], d[1], p4, d[0], p2, p1};
        return {^w7, w7};
    endfunction

    // Drive one input vector, let one rising edge sample it, settle after it
    task automatic apply(input logic [3:0] e, input logic [7:0] w, input logic s);
        bus.entrada    = e;
        bus.palabra_rx = w;
        bus.select_pos = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        bus.entrada = 4'h7; bus.palabra_rx = 8'hA5; bus.select_pos = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.led_out !== 4'b0000 || bus.display_left !== 7'b1111111 ||
            bus.display_right !== 7'b1111111) begin
            n_err++;
            $display("FAIL reset_async: led=%b left=%b right=%b required 0000/1111111/1111111",
                     bus.led_out, bus.display_left, bus.display_right);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.led_out !== 4'b0000 || bus.display_left !== 7'b1111111 ||
            bus.display_right !== 7'b1111111) begin
            n_err++;
            $display("FAIL reset_held: led=%b left=%b right=%b required 0000/1111111/1111111",
                     bus.led_out, bus.display_left, bus.display_right);
        end
        $display("reset: led=%b left=%b right=%b", bus.led_out, bus.display_left, bus.display_right);
        rst_n = 1'b1;
    endtask

    task automatic test_no_error;
        apply(4'b1010, 8'b11010010, 1'b0);
        n_cmp++;
        if (bus.led_out !== 4'b1010 || bus.display_left !== 7'b0001000 ||
            bus.display_right !== 7'b0001000) begin
            n_err++;
            $display("FAIL clean_A: led=%b left=%b right=%b required 1010/0001000/0001000",
                     bus.led_out, bus.display_left, bus.display_right);
        end
        $display("clean_A: led=%b left=%b right=%b", bus.led_out, bus.display_left, bus.display_right);
        // Clean word with position display selected shows digit 0
        apply(4'b1010, 8'b11010010, 1'b1);
        n_cmp++;
        if (bus.display_right !== 7'b1000000) begin
            n_err++;
            $display("FAIL clean_pos0: right=%b required 1000000", bus.display_right);
        end
        for (int n = 0; n < 16; n++) begin
            apply(4'(15 - n), encode(4'(n)), 1'b0);
            n_cmp++;
            if (bus.led_out !== 4'(n) || bus.display_right !== glyph(4'(n)) ||
                bus.display_left !== glyph(4'(15 - n))) begin
                n_err++;
                $display("FAIL clean_sweep n=%0d: led=%b right=%b left=%b required %b/%b/%b",
                         n, bus.led_out, bus.display_right, bus.display_left,
                         4'(n), glyph(4'(n)), glyph(4'(15 - n)));
            end
        end
    endtask

    task automatic test_single_error;
        // Position 3 (d1) flipped in the 1010 codeword
        apply(4'b1010, 8'b11010110, 1'b1);
        n_cmp++;
        if (bus.led_out !== 4'b1010 || bus.display_right !== 7'b0110000) begin
            n_err++;
            $display("FAIL single_pos3: led=%b right=%b required 1010/0110000",
                     bus.led_out, bus.display_right);
        end
        $display("single_pos3: led=%b right=%b", bus.led_out, bus.display_right);
        // Overall parity bit flipped: data untouched, position 8
        apply(4'b1010, 8'b01010010, 1'b1);
        n_cmp++;
        if (bus.led_out !== 4'b1010 || bus.display_right !== 7'b0000000) begin
            n_err++;
            $display("FAIL single_pos8: led=%b right=%b required 1010/0000000",
                     bus.led_out, bus.display_right);
        end
        $display("single_pos8: led=%b right=%b", bus.led_out, bus.display_right);
    endtask

    task automatic test_double_error;
        // 11011110: positions 3 and 4 flipped, s=7, pe=0.
        // Raw data d4..d1 = bits 6,5,4,2 = 1,0,1,1.
        apply(4'b0000, 8'b11011110, 1'b1);
        n_cmp++;
        if (bus.led_out !== 4'b1011 || bus.display_right !== 7'b0000110) begin
            n_err++;
            $display("FAIL double_s7_sel1: led=%b right=%b required 1011/0000110",
                     bus.led_out, bus.display_right);
        end
        $display("double_s7: led=%b right=%b", bus.led_out, bus.display_right);
        apply(4'b0000, 8'b11011110, 1'b0);
        n_cmp++;
        if (bus.display_right !== 7'b0000110 || bus.display_left !== 7'b1000000) begin
            n_err++;
            $display("FAIL double_s7_sel0: right=%b left=%b required 0000110/1000000",
                     bus.display_right, bus.display_left);
        end
        // Bits 0 and 1 flipped in the 0000 codeword: s=3, raw data 0000
        apply(4'b0000, 8'b00000011, 1'b0);
        n_cmp++;
        if (bus.led_out !== 4'b0000 || bus.display_right !== 7'b0000110) begin
            n_err++;
            $display("FAIL double_s3: led=%b right=%b required 0000/0000110",
                     bus.led_out, bus.display_right);
        end
    endtask

    task automatic test_single_sweep;
        logic [7:0] cw;
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < 8; k++) begin
                cw = encode(4'(n));
                cw[k] = ~cw[k];
                apply(4'(n), cw, 1'b1);
                n_cmp++;
                if (bus.led_out !== 4'(n) || bus.display_right !== glyph(4'(k + 1))) begin
                    n_err++;
                    $display("FAIL sweep n=%0d flip=%0d: led=%b right=%b required %b/%b",
                             n, k, bus.led_out, bus.display_right, 4'(n), glyph(4'(k + 1)));
                end
            end
        end
        $display("sweep: 128 single-bit flips applied");
    endtask

    task automatic test_back_to_back;
        // Consecutive cycles with different vectors; each edge reflects only its own inputs
        apply(4'h3, encode(4'h5), 1'b0);
        n_cmp++;
        if (bus.led_out !== 4'h5 || bus.display_left !== 7'b0110000 || bus.display_right !== 7'b0010010) begin
            n_err++;
            $display("FAIL b2b_0: led=%b left=%b right=%b required 0101/0110000/0010010",
                     bus.led_out, bus.display_left, bus.display_right);
        end
        apply(4'hC, 8'b11011110, 1'b0);
        n_cmp++;
        if (bus.led_out !== 4'b1011 || bus.display_left !== 7'b1000110 || bus.display_right !== 7'b0000110) begin
            n_err++;
            $display("FAIL b2b_1: led=%b left=%b right=%b required 1011/1000110/0000110",
                     bus.led_out, bus.display_left, bus.display_right);
        end
        apply(4'hF, encode(4'h9), 1'b1);
        n_cmp++;
        if (bus.led_out !== 4'h9 || bus.display_left !== 7'b0001110 || bus.display_right !== 7'b1000000) begin
            n_err++;
            $display("FAIL b2b_2: led=%b left=%b right=%b required 1001/0001110/1000000",
                     bus.led_out, bus.display_left, bus.display_right);
        end
        // Input change between edges must not reach the outputs
        bus.entrada = 4'h1; bus.palabra_rx = encode(4'h2); bus.select_pos = 1'b0;
        #2;
        n_cmp++;
        if (bus.led_out !== 4'h9 || bus.display_left !== 7'b0001110) begin
            n_err++;
            $display("FAIL b2b_hold: led=%b left=%b required 1001/0001110",
                     bus.led_out, bus.display_left);
        end
        $display("back_to_back: led=%b left=%b right=%b", bus.led_out, bus.display_left, bus.display_right);
    endtask

    task automatic test_reset_mid;
        apply(4'hA, encode(4'h6), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.led_out !== 4'b0000 || bus.display_left !== 7'b1111111 ||
            bus.display_right !== 7'b1111111) begin
            n_err++;
            $display("FAIL reset_mid: led=%b left=%b right=%b required 0000/1111111/1111111",
                     bus.led_out, bus.display_left, bus.display_right);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'h6, encode(4'hD), 1'b0);
        n_cmp++;
        if (bus.led_out !== 4'hD || bus.display_left !== 7'b0000010 || bus.display_right !== 7'b0100001) begin
            n_err++;
            $display("FAIL reset_release: led=%b left=%b right=%b required 1101/0000010/0100001",
                     bus.led_out, bus.display_left, bus.display_right);
        end
        $display("reset_mid: led=%b left=%b right=%b", bus.led_out, bus.display_left, bus.display_right);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_no_error();
        test_single_error();
        test_double_error();
        test_single_sweep();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
